// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine driving one valid/addr_ok/data_ok bus transaction.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses abort with resp_err and issue no bus request.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_ls_flag,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam logic [2:0] LS_NONE    = 3'd0;
  localparam logic [2:0] LS_BTYE    = 3'd1;
  localparam logic [2:0] LS_BTYE_U  = 3'd2;
  localparam logic [2:0] LS_HALFW   = 3'd3;
  localparam logic [2:0] LS_HALFW_U = 3'd4;
  localparam logic [2:0] LS_WORD    = 3'd5;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [2:0]  flag_q;
  logic        write_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] tmo_cnt;
  logic [31:0] tmo_next;
  logic        tmo_hit;
  logic        misalign;

  function automatic logic is_mem_op(input logic [2:0] f);
    is_mem_op = (f == LS_BTYE) || (f == LS_BTYE_U) || (f == LS_HALFW) ||
                (f == LS_HALFW_U) || (f == LS_WORD);
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] f);
    case (f)
      LS_BTYE, LS_BTYE_U:   size_of = MSIZE1;
      LS_HALFW, LS_HALFW_U: size_of = MSIZE2;
      default:              size_of = MSIZE4;
    endcase
  endfunction

  function automatic logic [3:0] strobe_of(input logic [2:0] f, input logic w, input logic [1:0] lo);
    strobe_of = 4'b0000;
    if (w) begin
      case (f)
        LS_BTYE, LS_BTYE_U:   strobe_of = 4'b0001 << lo;
        LS_HALFW, LS_HALFW_U: strobe_of = 4'b0011 << {lo[1], 1'b0};
        default:              strobe_of = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] lanes_of(input logic [2:0] f, input logic [31:0] wd);
    case (f)
      LS_BTYE, LS_BTYE_U:   lanes_of = {4{wd[7:0]}};
      LS_HALFW, LS_HALFW_U: lanes_of = {2{wd[15:0]}};
      default:              lanes_of = wd;
    endcase
  endfunction

  // Align the addressed lane to bit 0, then sign- or zero-extend by access type.
  function automatic logic [31:0] load_extract(input logic [2:0] f, input logic [1:0] lo,
                                               input logic [31:0] raw);
    logic [31:0] sh;
    load_extract = 32'd0;
    sh = 32'd0;
    case (f)
      LS_BTYE: begin
        sh = raw >> {lo, 3'b000};
        load_extract = {{24{sh[7]}}, sh[7:0]};
      end
      LS_BTYE_U: begin
        sh = raw >> {lo, 3'b000};
        load_extract = {24'd0, sh[7:0]};
      end
      LS_HALFW: begin
        sh = raw >> {lo[1], 4'b0000};
        load_extract = {{16{sh[15]}}, sh[15:0]};
      end
      LS_HALFW_U: begin
        sh = raw >> {lo[1], 4'b0000};
        load_extract = {16'd0, sh[15:0]};
      end
      LS_WORD: load_extract = raw;
      default: load_extract = 32'd0;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (((req_ls_flag == LS_HALFW) || (req_ls_flag == LS_HALFW_U)) && req_addr[0]) ||
                    ((req_ls_flag == LS_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign tmo_next = tmo_cnt + 32'd1;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_next == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      dreq_valid  <= 1'b0;
      dreq_addr   <= 32'd0;
      dreq_size   <= 3'd0;
      dreq_strobe <= 4'd0;
      dreq_data   <= 32'd0;
      resp_valid  <= 1'b0;
      resp_data   <= 32'd0;
      resp_err    <= 1'b0;
      tmo_cnt     <= 32'd0;
      flag_q      <= LS_NONE;
      write_q     <= 1'b0;
      addr_lo_q   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            flag_q      <= req_ls_flag;
            write_q     <= req_write;
            addr_lo_q   <= req_addr[1:0];
            dreq_addr   <= req_addr;
            dreq_size   <= size_of(req_ls_flag);
            dreq_strobe <= strobe_of(req_ls_flag, req_write, req_addr[1:0]);
            dreq_data   <= lanes_of(req_ls_flag, req_wdata);
            resp_data   <= 32'd0;
            resp_err    <= 1'b0;
            req_ready   <= 1'b0;
            if (!is_mem_op(req_ls_flag)) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
            end else if (misalign) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= S_REQ;
              dreq_valid <= 1'b1;
              tmo_cnt    <= 32'd0;
            end
          end
        end
        // Address phase: request held stable until the bus accepts it.
        S_REQ: begin
          if (dresp_addr_ok && dresp_data_ok) begin
            state      <= S_DONE;
            dreq_valid <= 1'b0;
            resp_valid <= 1'b1;
            if (!write_q) resp_data <= load_extract(flag_q, addr_lo_q, dresp_data);
          end else if (tmo_hit) begin
            state      <= S_DONE;
            dreq_valid <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 32'd0;
          end else begin
            tmo_cnt <= tmo_next;
            if (dresp_addr_ok) begin
              state      <= S_WAIT;
              dreq_valid <= 1'b0;
            end
          end
        end
        // Data phase: address already accepted, waiting on data_ok.
        S_WAIT: begin
          if (dresp_data_ok) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            if (!write_q) resp_data <= load_extract(flag_q, addr_lo_q, dresp_data);
          end else if (tmo_hit) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 32'd0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          dreq_valid <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors for mem_access_unit, a second instance exercises TIMEOUT_CYCLES=8.
// Alignment expectations follow MEM_ALIGN_CHECK_EN when the bench is compiled with it.
module tb_mem_access_unit;

  localparam logic [2:0] LS_NONE    = 3'd0;
  localparam logic [2:0] LS_BTYE    = 3'd1;
  localparam logic [2:0] LS_BTYE_U  = 3'd2;
  localparam logic [2:0] LS_HALFW   = 3'd3;
  localparam logic [2:0] LS_HALFW_U = 3'd4;
  localparam logic [2:0] LS_WORD    = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_t = 1'b0;
  logic [2:0]  req_ls_flag = 3'd0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic        addr_ok_t = 1'b0;
  logic        data_ok_t = 1'b0;
  logic [31:0] dresp_data = 32'd0;

  logic        req_ready, dreq_valid, resp_valid, resp_err;
  logic [31:0] dreq_addr, dreq_data, resp_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;

  logic        req_ready_t, dreq_valid_t, resp_valid_t, resp_err_t;
  logic [31:0] dreq_addr_t, dreq_data_t, resp_data_t;
  logic [2:0]  dreq_size_t;
  logic [3:0]  dreq_strobe_t;

  int n_chk = 0;
  int n_err = 0;

  logic        s_valid, s_rv;
  logic [31:0] s_addr, s_data;
  logic [2:0]  s_size;
  logic [3:0]  s_strobe;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ls_flag(req_ls_flag), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(addr_ok), .dresp_data_ok(data_ok), .dresp_data(dresp_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut_tmo (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_ls_flag(req_ls_flag), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dreq_valid(dreq_valid_t), .dreq_addr(dreq_addr_t), .dreq_size(dreq_size_t),
    .dreq_strobe(dreq_strobe_t), .dreq_data(dreq_data_t),
    .dresp_addr_ok(addr_ok_t), .dresp_data_ok(data_ok_t), .dresp_data(dresp_data),
    .resp_valid(resp_valid_t), .resp_data(resp_data_t), .resp_err(resp_err_t)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Presents one op for one cycle; returns #1 after the accepting edge.
  task automatic accept_op(input logic [2:0] f, input logic w, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_ls_flag = f; req_write = w; req_addr = a; req_wdata = wd;
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Zero-wait transaction; snapshots the request in REQ, returns at the negedge of the DONE cycle.
  task automatic xfer_fast(input logic [2:0] f, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd);
    accept_op(f, w, a, wd);
    addr_ok = 1'b1; data_ok = 1'b1; dresp_data = rd;
    @(negedge clk);
    s_valid = dreq_valid; s_addr = dreq_addr; s_size = dreq_size;
    s_strobe = dreq_strobe; s_data = dreq_data; s_rv = resp_valid;
    next_cycle();
    addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [31:0] got_data;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_dreq_addr", dreq_addr, 32'd0);
    check_eq("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
    check_eq("rst_tmo_ready", 32'(req_ready_t), 32'd1);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    xfer_fast(LS_WORD, 1'b0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF);
    check_eq("lw_req_valid", 32'(s_valid), 32'd1);
    check_eq("lw_no_early_resp", 32'(s_rv), 32'd0);
    check_eq("lw_addr", s_addr, 32'h0000_1000);
    check_eq("lw_size", 32'(s_size), 32'd2);
    check_eq("lw_strobe", 32'(s_strobe), 32'd0);
    check_eq("lw_resp_valid", 32'(resp_valid), 32'd1);
    check_eq("lw_resp_data", resp_data, 32'hDEAD_BEEF);
    check_eq("lw_resp_err", 32'(resp_err), 32'd0);
    check_eq("lw_done_dreq_valid", 32'(dreq_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("lw_pulse_end", 32'(resp_valid), 32'd0);
    check_eq("lw_ready_back", 32'(req_ready), 32'd1);
    next_cycle();

    xfer_fast(LS_BTYE, 1'b0, 32'h0000_1003, 32'd0, 32'h8011_2233);
    check_eq("lb_size", 32'(s_size), 32'd0);
    check_eq("lb_data", resp_data, 32'hFFFF_FF80);
    next_cycle();

    // Non-memory op must clear the stale load result and skip the bus.
    accept_op(LS_NONE, 1'b0, 32'h0000_0000, 32'd0);
    @(negedge clk);
    check_eq("none_dreq_valid", 32'(dreq_valid), 32'd0);
    check_eq("none_resp_valid", 32'(resp_valid), 32'd1);
    check_eq("none_resp_data", resp_data, 32'd0);
    next_cycle();

    xfer_fast(LS_BTYE_U, 1'b0, 32'h0000_1003, 32'd0, 32'h8011_2233);
    check_eq("lbu_data", resp_data, 32'h0000_0080);
    next_cycle();

    xfer_fast(LS_HALFW, 1'b0, 32'h0000_1002, 32'd0, 32'h8011_2233);
    check_eq("lh_size", 32'(s_size), 32'd1);
    check_eq("lh_data", resp_data, 32'hFFFF_8011);
    next_cycle();

    xfer_fast(LS_HALFW_U, 1'b0, 32'h0000_1000, 32'd0, 32'h1234_F00D);
    check_eq("lhu_data", resp_data, 32'h0000_F00D);
    next_cycle();

    xfer_fast(LS_HALFW, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF);
    check_eq("sh_size", 32'(s_size), 32'd1);
    check_eq("sh_strobe", 32'(s_strobe), 32'b1100);
    check_eq("sh_data", s_data, 32'hABCD_ABCD);
    check_eq("sh_resp_data", resp_data, 32'd0);
    next_cycle();

    xfer_fast(LS_BTYE, 1'b1, 32'h0000_2001, 32'h1234_5678, 32'd0);
    check_eq("sb_strobe", 32'(s_strobe), 32'b0010);
    check_eq("sb_data", s_data, 32'h7878_7878);
    next_cycle();

    xfer_fast(LS_WORD, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 32'd0);
    check_eq("sw_size", 32'(s_size), 32'd2);
    check_eq("sw_strobe", 32'(s_strobe), 32'b1111);
    check_eq("sw_data", s_data, 32'hCAFE_F00D);
    next_cycle();

    // Stalled bus: addr_ok low 5 cycles (stray data_ok ignored), then data_ok 3 cycles later.
    accept_op(LS_WORD, 1'b0, 32'h0000_4004, 32'd0);
    for (int i = 0; i < 5; i++) begin
      addr_ok = 1'b0; data_ok = (i == 2); dresp_data = 32'h1111_1111;
      @(negedge clk);
      check_eq("stall_dreq_valid", 32'(dreq_valid), 32'd1);
      check_eq("stall_addr", dreq_addr, 32'h0000_4004);
      check_eq("stall_size", 32'(dreq_size), 32'd2);
      check_eq("stall_ready", 32'(req_ready), 32'd0);
      check_eq("stall_no_resp", 32'(resp_valid), 32'd0);
      next_cycle();
    end
    addr_ok = 1'b1; data_ok = 1'b0;
    @(negedge clk);
    check_eq("stall_addr_phase", 32'(dreq_valid), 32'd1);
    next_cycle();
    addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_ok = (i == 2); dresp_data = 32'h55AA_0FF0;
      @(negedge clk);
      check_eq("wait_dreq_valid", 32'(dreq_valid), 32'd0);
      check_eq("wait_ready", 32'(req_ready), 32'd0);
      check_eq("wait_no_resp", 32'(resp_valid), 32'd0);
      next_cycle();
    end
    data_ok = 1'b0;
    pulses = 0;
    got_data = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        pulses++;
        got_data = resp_data;
      end
      next_cycle();
    end
    check_eq("stall_pulses", 32'(pulses), 32'd1);
    check_eq("stall_data", got_data, 32'h55AA_0FF0);

    // Timeout instance: no addr_ok ever, abort after 8 REQ cycles.
    req_valid_t = 1'b1; req_ls_flag = LS_WORD; req_write = 1'b0; req_addr = 32'h0000_5000;
    next_cycle();
    req_valid_t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("tmo_req_valid", 32'(dreq_valid_t), 32'd1);
      check_eq("tmo_no_resp", 32'(resp_valid_t), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_eq("tmo_resp_valid", 32'(resp_valid_t), 32'd1);
    check_eq("tmo_resp_err", 32'(resp_err_t), 32'd1);
    check_eq("tmo_resp_data", resp_data_t, 32'd0);
    check_eq("tmo_dreq_drop", 32'(dreq_valid_t), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("tmo_pulse_end", 32'(resp_valid_t), 32'd0);
    check_eq("tmo_ready_back", 32'(req_ready_t), 32'd1);
    next_cycle();

    // Reset while waiting for data, then a late data_ok.
    accept_op(LS_WORD, 1'b0, 32'h0000_6000, 32'd0);
    addr_ok = 1'b1; data_ok = 1'b0;
    next_cycle();
    addr_ok = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstw_dreq_valid", 32'(dreq_valid), 32'd0);
    check_eq("rstw_ready", 32'(req_ready), 32'd1);
    next_cycle();
    data_ok = 1'b1; dresp_data = 32'h7777_7777;
    next_cycle();
    data_ok = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
      next_cycle();
    end
    check_eq("rstw_no_resp", 32'(pulses), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    accept_op(LS_WORD, 1'b0, 32'h0000_1002, 32'd0);
    @(negedge clk);
    check_eq("mis_dreq_valid", 32'(dreq_valid), 32'd0);
    check_eq("mis_resp_valid", 32'(resp_valid), 32'd1);
    check_eq("mis_resp_err", 32'(resp_err), 32'd1);
    check_eq("mis_resp_data", resp_data, 32'd0);
    next_cycle();
    accept_op(LS_HALFW, 1'b0, 32'h0000_1003, 32'd0);
    @(negedge clk);
    check_eq("mish_resp_err", 32'(resp_err), 32'd1);
    check_eq("mish_dreq_valid", 32'(dreq_valid), 32'd0);
    next_cycle();
`else
    xfer_fast(LS_WORD, 1'b0, 32'h0000_1002, 32'd0, 32'h1122_3344);
    check_eq("unal_req_valid", 32'(s_valid), 32'd1);
    check_eq("unal_addr", s_addr, 32'h0000_1002);
    check_eq("unal_data", resp_data, 32'h1122_3344);
    check_eq("unal_err", 32'(resp_err), 32'd0);
    next_cycle();
    xfer_fast(LS_WORD, 1'b1, 32'h0000_1003, 32'h0102_0304, 32'd0);
    check_eq("unal_sw_strobe", 32'(s_strobe), 32'b1111);
    next_cycle();
    xfer_fast(LS_HALFW, 1'b0, 32'h0000_1003, 32'd0, 32'hAABB_1122);
    check_eq("unal_lh_data", resp_data, 32'hFFFF_AABB);
    next_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
